// File: rtl/clint_pkg.sv
// Types, instruction encodings and mstatus helpers for the core-local
// interrupt/exception controller.
package clint_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_MEPC    = 3'd1,
        W_MCAUSE  = 3'd2,
        W_MSTATUS = 3'd3,
        W_MRET    = 3'd4,
        ASSERT    = 3'd5
    } state_t;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] CAUSE_ECALL    = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK   = 32'd3;
    localparam logic [31:0] CAUSE_INT_FLAG = 32'h8000_0000;

    // Trap entry: stash MIE into MPIE and disable interrupts.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE and set MPIE.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/clint_int_prio.sv
// Lowest-index-wins priority encoder over the external interrupt lines.
module clint_int_prio #(
    parameter int   INT_NUM = 8,
    localparam int  IDX_W   = (INT_NUM > 1) ? $clog2(INT_NUM) : 1
) (
    input  logic [INT_NUM-1:0] int_flag,
    output logic               int_valid,
    output logic [IDX_W-1:0]   int_index
);

    // Scan from the top down so the lowest set line is the last one written.
    always_comb begin
        int_valid = |int_flag;
        int_index = '0;
        for (int i = INT_NUM - 1; i >= 0; i--) begin
            if (int_flag[i]) begin
                int_index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/define.sv
// Shared CSR bus widths and CSR addresses used by the core.
`ifndef CLINT_DEFINE_SV
`define CLINT_DEFINE_SV

`define CSR_ADDR_BUS 31:0
`define CSR_DATA_BUS 31:0

`define CSR_MSTATUS 32'h0000_0300
`define CSR_MEPC    32'h0000_0341
`define CSR_MCAUSE  32'h0000_0342

`endif

// File: rtl/clint_ctrl.sv
// Core-local interrupt/exception controller: detects ecall/ebreak/mret and
// enabled external interrupts in ID, sequences mepc/mcause/mstatus writes
// into the CSR file one per cycle while holding the pipeline, then issues a
// one-cycle redirect to mtvec (trap) or mepc (mret).
`include "define.sv"

module clint_ctrl
    import clint_pkg::*;
#(
    parameter int INT_NUM        = 8,
    parameter int INT_CAUSE_BASE = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [31:0]          inst_i,
    input  logic [31:0]          inst_addr_i,
    input  logic [INT_NUM-1:0]   int_flag_i,
    input  logic                 jump_flag_i,
    input  logic [31:0]          jump_addr_i,
    input  logic                 ex_csr_wen_i,
    input  logic [31:0]          csr_mtvec_i,
    input  logic [31:0]          csr_mepc_i,
    input  logic [31:0]          csr_mstatus_i,
    output logic                 clint_wen_o,
    output logic [`CSR_ADDR_BUS] clint_waddr_o,
    output logic [`CSR_DATA_BUS] clint_wdata_o,
    output logic                 hold_flag_o,
    output logic                 int_assert_o,
    output logic [31:0]          int_addr_o
);

    localparam int IDX_W = (INT_NUM > 1) ? $clog2(INT_NUM) : 1;

    state_t      state_reg;
    logic [31:0] cause_reg;
    logic [31:0] epc_reg;
    logic [31:0] mstatus_reg;
    logic        mret_reg;

    logic             int_valid;
    logic [IDX_W-1:0] int_index;

    logic        ev_ecall;
    logic        ev_ebreak;
    logic        ev_mret;
    logic        ev_int;
    logic        ev_any;
    logic [31:0] int_cause;

    clint_int_prio #(
        .INT_NUM (INT_NUM)
    ) u_int_prio (
        .int_flag  (int_flag_i),
        .int_valid (int_valid),
        .int_index (int_index)
    );

    // Event decode; only meaningful while IDLE (the FSM ignores it elsewhere).
    always_comb begin
        ev_ecall  = (inst_i == INST_ECALL);
        ev_ebreak = (inst_i == INST_EBREAK);
        ev_mret   = (inst_i == INST_MRET);
        ev_int    = int_valid && csr_mstatus_i[MSTATUS_MIE];
        ev_any    = ev_ecall || ev_ebreak || ev_mret || ev_int;
        int_cause = CAUSE_INT_FLAG | (32'(INT_CAUSE_BASE) + 32'(int_index));
    end

    // Trap/mret sequencer; W_* states stall in place while EX owns the CSR port.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg   <= IDLE;
            cause_reg   <= '0;
            epc_reg     <= '0;
            mstatus_reg <= '0;
            mret_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ev_ecall || ev_ebreak) begin
                        state_reg   <= W_MEPC;
                        cause_reg   <= ev_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                        epc_reg     <= inst_addr_i;
                        mstatus_reg <= csr_mstatus_i;
                        mret_reg    <= 1'b0;
                    end else if (ev_mret) begin
                        state_reg   <= W_MRET;
                        mstatus_reg <= csr_mstatus_i;
                        mret_reg    <= 1'b1;
                    end else if (ev_int) begin
                        // An in-flight EX redirect is where execution would resume.
                        state_reg   <= W_MEPC;
                        cause_reg   <= int_cause;
                        epc_reg     <= jump_flag_i ? jump_addr_i : inst_addr_i;
                        mstatus_reg <= csr_mstatus_i;
                        mret_reg    <= 1'b0;
                    end
                end
                W_MEPC:    if (!ex_csr_wen_i) state_reg <= W_MCAUSE;
                W_MCAUSE:  if (!ex_csr_wen_i) state_reg <= W_MSTATUS;
                W_MSTATUS: if (!ex_csr_wen_i) state_reg <= ASSERT;
                W_MRET:    if (!ex_csr_wen_i) state_reg <= ASSERT;
                ASSERT:    state_reg <= IDLE;
                default:   state_reg <= IDLE;
            endcase
        end
    end

    // CSR write port and redirect; must follow ex_csr_wen_i in the same cycle.
    always_comb begin
        clint_wen_o   = 1'b0;
        clint_waddr_o = '0;
        clint_wdata_o = '0;
        int_assert_o  = 1'b0;
        int_addr_o    = '0;
        case (state_reg)
            W_MEPC: if (!ex_csr_wen_i) begin
                clint_wen_o   = 1'b1;
                clint_waddr_o = `CSR_MEPC;
                clint_wdata_o = epc_reg;
            end
            W_MCAUSE: if (!ex_csr_wen_i) begin
                clint_wen_o   = 1'b1;
                clint_waddr_o = `CSR_MCAUSE;
                clint_wdata_o = cause_reg;
            end
            W_MSTATUS: if (!ex_csr_wen_i) begin
                clint_wen_o   = 1'b1;
                clint_waddr_o = `CSR_MSTATUS;
                clint_wdata_o = trap_mstatus(mstatus_reg);
            end
            W_MRET: if (!ex_csr_wen_i) begin
                clint_wen_o   = 1'b1;
                clint_waddr_o = `CSR_MSTATUS;
                clint_wdata_o = mret_mstatus(mstatus_reg);
            end
            ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = mret_reg ? csr_mepc_i : csr_mtvec_i;
            end
            default: ;
        endcase
    end

    // Stall as soon as an event is seen in IDLE; forced low while in reset.
    always_comb begin
        hold_flag_o = rst_n_i && ((state_reg != IDLE) || ev_any);
    end

endmodule

// File: tb/tb_clint_ctrl.sv
// Scoreboard bench for clint_ctrl: the driver issues events and pushes the
// expected CSR writes, redirects and hold windows; the monitor compares them.
module tb_clint_ctrl;

    localparam logic [31:0] A_MSTATUS = 32'h300;
    localparam logic [31:0] A_MEPC    = 32'h341;
    localparam logic [31:0] A_MCAUSE  = 32'h342;
    localparam logic [31:0] I_NOP     = 32'h0000_0013;
    localparam logic [31:0] I_ECALL   = 32'h0000_0073;
    localparam logic [31:0] I_EBREAK  = 32'h0010_0073;
    localparam logic [31:0] I_MRET    = 32'h3020_0073;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] inst_i, inst_addr_i, jump_addr_i;
    logic [7:0]  int_flag_i;
    logic        jump_flag_i, ex_csr_wen_i;
    logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        clint_wen_o, hold_flag_o, int_assert_o;
    logic [31:0] clint_waddr_o, clint_wdata_o, int_addr_o;

    clint_ctrl #(.INT_NUM(8), .INT_CAUSE_BASE(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .int_flag_i(int_flag_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .ex_csr_wen_i(ex_csr_wen_i), .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
        .csr_mstatus_i(csr_mstatus_i), .clint_wen_o(clint_wen_o), .clint_waddr_o(clint_waddr_o),
        .clint_wdata_o(clint_wdata_o), .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o),
        .int_addr_o(int_addr_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
    typedef struct { logic [31:0] addr; int cyc; } rd_t;
    typedef struct { int s; int e; } win_t;

    wr_t  exp_wr[$];
    rd_t  exp_rd[$];
    win_t wins[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ms_trap(input logic [31:0] ms);
        return (ms & ~32'h88) | ({31'd0, ms[3]} << 7);
    endfunction

    function automatic logic [31:0] ms_ret(input logic [31:0] ms);
        return (ms & ~32'h88) | ({31'd0, ms[7]} << 3) | 32'h80;
    endfunction

    function automatic int lowest_line(input logic [7:0] f);
        for (int i = 0; i < 8; i++) if (f[i]) return i;
        return -1;
    endfunction

    // ---------------- driver ----------------
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one ID-stage situation at the current cycle and carry it to idle.
    // stall bit k drives ex_csr_wen_i at detection+k; rst_at>0 pulses reset there.
    task automatic run_event(input logic [31:0] inst, input logic [7:0] flags,
                             input logic [31:0] ms, input logic [31:0] pc,
                             input bit jf, input logic [31:0] ja,
                             input logic [15:0] stall, input bit keep_int,
                             input int rst_at);
        int n, t, e, nw;
        logic [31:0] wa[3];
        logic [31:0] wd[3];
        int          wc[3];
        logic [31:0] cause, epc, redir;
        bit          is_trap, is_mret;
        inst_i = inst; int_flag_i = flags; csr_mstatus_i = ms;
        inst_addr_i = pc; jump_flag_i = jf; jump_addr_i = ja; ex_csr_wen_i = 1'b0;
        n = cyc;
        is_trap = 1'b0; is_mret = 1'b0; cause = 32'd0; epc = pc;
        if (inst == I_ECALL) begin is_trap = 1'b1; cause = 32'd11; end
        else if (inst == I_EBREAK) begin is_trap = 1'b1; cause = 32'd3; end
        else if (inst == I_MRET) is_mret = 1'b1;
        else if (flags != 8'd0 && ms[3]) begin
            is_trap = 1'b1;
            cause = 32'h8000_0000 | (32'd16 + 32'(lowest_line(flags)));
            epc = jf ? ja : pc;
        end
        if (!is_trap && !is_mret) begin
            $display("txn cyc=%0d inst=%h flags=%h ms=%h -> no event", n, inst, flags, ms);
            next_cycle();
            inst_i = I_NOP;
            if (!keep_int) int_flag_i = 8'd0;
            return;
        end
        nw = is_trap ? 3 : 1;
        wa[0] = is_trap ? A_MEPC : A_MSTATUS;  wd[0] = is_trap ? epc : ms_ret(ms);
        wa[1] = A_MCAUSE;                       wd[1] = cause;
        wa[2] = A_MSTATUS;                      wd[2] = ms_trap(ms);
        t = n;
        for (int k = 0; k < nw; k++) begin
            t++;
            while ((t - n) < 16 && stall[t - n]) t++;
            wc[k] = t;
            exp_wr.push_back('{wa[k], wd[k], t});
        end
        for (int k = nw; k < 3; k++) wc[k] = -10;
        e = t + 1;
        redir = is_mret ? csr_mepc_i : csr_mtvec_i;
        exp_rd.push_back('{redir, e});
        wins.push_back('{n, e});
        $display("txn cyc=%0d inst=%h flags=%h ms=%h -> %s cause=%h epc=%h redirect=%h at %0d",
                 n, inst, flags, ms, is_mret ? "mret" : "trap", cause, epc, redir, e);
        for (int c = n + 1; c <= e + 1; c++) begin
            next_cycle();
            inst_i = I_NOP; jump_flag_i = 1'b0;
            if (!keep_int) int_flag_i = 8'd0;
            ex_csr_wen_i = (c <= e && (c - n) < 16) ? stall[c - n] : 1'b0;
            // Behave like the CSR file: a write lands one cycle after it is presented.
            for (int k = 0; k < nw; k++) begin
                if (wc[k] == c - 1) begin
                    if (wa[k] == A_MEPC) csr_mepc_i = wd[k];
                    if (wa[k] == A_MSTATUS) csr_mstatus_i = wd[k];
                end
            end
            if (rst_at > 0 && (c - n) == rst_at) begin
                #1;
                rst_n_i = 1'b0;
                exp_wr.delete(); exp_rd.delete(); wins.delete();
                $display("txn cyc=%0d reset asserted mid-sequence", c);
                next_cycle(); next_cycle();
                rst_n_i = 1'b1; ex_csr_wen_i = 1'b0;
                next_cycle();
                return;
            end
        end
    endtask

    initial begin
        logic [15:0] st;
        logic [31:0] ins, ms;
        logic [7:0]  fl;
        int          kind;
        rst_n_i = 1'b0; inst_i = I_NOP; inst_addr_i = 32'd0; int_flag_i = 8'd0;
        jump_flag_i = 1'b0; jump_addr_i = 32'd0; ex_csr_wen_i = 1'b0;
        csr_mtvec_i = 32'h400; csr_mepc_i = 32'd0; csr_mstatus_i = 32'd0;
        repeat (3) next_cycle();
        rst_n_i = 1'b1;
        repeat (2) next_cycle();

        // ecall, trap to mtvec
        run_event(I_ECALL, 8'd0, 32'h8, 32'h100, 1'b0, 32'd0, 16'd0, 1'b0, -1);
        // interrupt line 2 wins over line 5, epc follows the EX redirect
        run_event(I_NOP, 8'b0010_0100, 32'h8, 32'h300, 1'b1, 32'h200, 16'd0, 1'b0, -1);
        // masked, then enabled the next cycle
        run_event(I_NOP, 8'h01, 32'h0, 32'h500, 1'b0, 32'd0, 16'd0, 1'b1, -1);
        run_event(I_NOP, 8'h01, 32'h8, 32'h504, 1'b0, 32'd0, 16'd0, 1'b0, -1);
        // mret
        csr_mepc_i = 32'h104;
        run_event(I_MRET, 8'd0, 32'h80, 32'h600, 1'b0, 32'd0, 16'd0, 1'b0, -1);
        // EX owns the CSR port during W_MCAUSE for two cycles
        run_event(I_EBREAK, 8'd0, 32'h8, 32'h700, 1'b0, 32'd0, 16'b1100, 1'b0, -1);
        // ecall beats a pending interrupt, which is then masked by the new mstatus
        run_event(I_ECALL, 8'h10, 32'h8, 32'h800, 1'b0, 32'd0, 16'd0, 1'b1, -1);
        run_event(I_NOP, 8'h10, csr_mstatus_i, 32'h804, 1'b0, 32'd0, 16'd0, 1'b1, -1);
        run_event(I_NOP, 8'h10, csr_mstatus_i, 32'h808, 1'b0, 32'd0, 16'd0, 1'b0, -1);
        // reset while in W_MSTATUS
        run_event(I_ECALL, 8'd0, 32'h8, 32'h900, 1'b0, 32'd0, 16'd0, 1'b0, 3);
        repeat (2) next_cycle();

        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 5));
            fl = 8'($urandom);
            ms = $urandom;
            st = 16'd0;
            for (int k = 1; k <= 8; k++) st[k] = ($urandom_range(0, 3) == 0);
            case (kind)
                0: ins = I_ECALL;
                1: ins = I_EBREAK;
                2: ins = I_MRET;
                3: begin ins = I_NOP; ms[3] = 1'b1; if (fl == 8'd0) fl = 8'h80; end
                4: begin ins = I_NOP; ms[3] = 1'b0; end
                default: ins = $urandom;
            endcase
            csr_mtvec_i = $urandom & ~32'h3;
            if ($urandom_range(0, 1) == 1) csr_mepc_i = $urandom & ~32'h3;
            run_event(ins, fl, ms, $urandom & ~32'h3, 1'($urandom), $urandom & ~32'h3,
                      st, 1'b0, -1);
        end
        repeat (3) next_cycle();
        done = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    initial begin
        wr_t w;
        rd_t r;
        logic exp_hold;
        while (!done) begin
            @(negedge clk_i);
            if (cyc > 20000) begin
                check("timeout", 64'(cyc), 64'd20000);
                break;
            end
            if (!rst_n_i) begin
                check("reset_outputs",
                      {29'd0, clint_wen_o, hold_flag_o, int_assert_o} | 64'(clint_waddr_o | clint_wdata_o | int_addr_o),
                      64'd0);
                continue;
            end
            while (wins.size() > 0 && wins[0].e < cyc) void'(wins.pop_front());
            exp_hold = (wins.size() > 0 && wins[0].s <= cyc);
            check("hold_flag", 64'(hold_flag_o), 64'(exp_hold));
            if (clint_wen_o) begin
                check("wen_during_ex_write", 64'(ex_csr_wen_i), 64'd0);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", {clint_waddr_o, clint_wdata_o}, 64'd0);
                end else begin
                    w = exp_wr.pop_front();
                    check("write_addr", 64'(clint_waddr_o), 64'(w.addr));
                    check("write_data", 64'(clint_wdata_o), 64'(w.data));
                    check("write_cycle", 64'(cyc), 64'(w.cyc));
                end
            end else begin
                check("idle_write_bus", {clint_waddr_o, clint_wdata_o}, 64'd0);
            end
            if (int_assert_o) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_assert", 64'(int_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    r = exp_rd.pop_front();
                    check("redirect_addr", 64'(int_addr_o), 64'(r.addr));
                    check("redirect_cycle", 64'(cyc), 64'(r.cyc));
                end
            end else begin
                check("idle_int_addr", 64'(int_addr_o), 64'd0);
            end
        end
        check("writes_outstanding", 64'(exp_wr.size()), 64'd0);
        check("redirects_outstanding", 64'(exp_rd.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
